hazard_scoreboard: RTL and testbench

- Parametrised successor to the pipeline's combinational branch/load-use stall line.
- Detects load-use hazards against the IE stage, as before.
- Adds a per-register scoreboard for long-latency ops (mul/div, FPU) covering integer and, optionally, float register files.
- Sits beside the ID stage; its stall output freezes PC/IF/ID and bubbles IE.

---
 rtl/hazard_scoreboard_if.sv | 59 +++++
 rtl/hazard_scoreboard.sv | 195 +++++++++++++++++++
 tb/tb_hazard_scoreboard.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if
// Bundles the ID-stage query, IE-stage load information, late writeback
// clears and the scoreboard results into one interface.
//   master : pipeline side; drives ID/IE/WB information, reads stall and state
//   slave  : scoreboard side; reads pipeline information, drives the results
// Signals:
//   id_*      instruction currently in ID (sources, destination, latency)
//   ext_hold  stall raised elsewhere in the pipeline; blocks issue
//   ie_*      instruction currently in IE (load-use detection)
//   wb_clr*   retirement of an unknown-latency operation
//   stall, stall_cause, busy_int, busy_fp, pend_cnt, err : scoreboard results
interface hazard_scoreboard_if #(
    parameter int NREG  = 32,
    parameter int NSRC  = 3,
    parameter int CNT_W = 6
);
    localparam int PCNT_W = $clog2(NREG * 2 + 1);

    logic                id_valid;
    logic [NSRC*5-1:0]   id_rs;
    logic [NSRC-1:0]     id_rs_use;
    logic [NSRC-1:0]     id_rs_float;
    logic [4:0]          id_rd;
    logic                id_rd_float;
    logic                id_wb;
    logic                id_long;
    logic [CNT_W-1:0]    id_lat;
    logic                ext_hold;
    logic                ie_valid;
    logic                ie_load;
    logic [4:0]          ie_rd;
    logic                ie_rd_float;
    logic                ie_wb;
    logic                wb_clr;
    logic [4:0]          wb_clr_rd;
    logic                wb_clr_float;
    logic                stall;
    logic [1:0]          stall_cause;
    logic [NREG-1:0]     busy_int;
    logic [NREG-1:0]     busy_fp;
    logic [PCNT_W-1:0]   pend_cnt;
    logic                err;

    modport master (
        output id_valid, id_rs, id_rs_use, id_rs_float, id_rd, id_rd_float,
               id_wb, id_long, id_lat, ext_hold,
               ie_valid, ie_load, ie_rd, ie_rd_float, ie_wb,
               wb_clr, wb_clr_rd, wb_clr_float,
        input  stall, stall_cause, busy_int, busy_fp, pend_cnt, err
    );

    modport slave (
        input  id_valid, id_rs, id_rs_use, id_rs_float, id_rd, id_rd_float,
               id_wb, id_long, id_lat, ext_hold,
               ie_valid, ie_load, ie_rd, ie_rd_float, ie_wb,
               wb_clr, wb_clr_rd, wb_clr_float,
        output stall, stall_cause, busy_int, busy_fp, pend_cnt, err
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
// Sits beside the ID stage. Detects load-use hazards against IE and keeps a
// per-register scoreboard for long-latency operations (fixed-latency
// countdowns and unknown-latency flags), for the integer file and optionally
// the float file. stall freezes PC/IF/ID and bubbles IE.
// Ports:
//   clk  clock
//   rst  synchronous active-high reset; discards all pending entries
//   sb   hazard_scoreboard_if.slave (ID/IE/WB inputs, stall/state outputs)
// Notes:
//   stall/stall_cause are combinational from the ID/IE inputs and the
//   registered scoreboard. busy_*, pend_cnt and err are registered.
module hazard_scoreboard #(
    parameter bit FLOAT = 1'b0,
    parameter int NREG  = 32,
    parameter int NSRC  = 3,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    hazard_scoreboard_if.slave sb
);
    localparam int IDX_W  = (NREG > 1) ? $clog2(NREG) : 1;
    localparam int PCNT_W = $clog2(NREG * 2 + 1);

    logic [NREG-1:0][CNT_W-1:0] cnt_int_r;
    logic [NREG-1:0][CNT_W-1:0] cnt_fp_r;
    logic [NREG-1:0][CNT_W-1:0] cnt_int_nxt_s;
    logic [NREG-1:0][CNT_W-1:0] cnt_fp_nxt_s;
    logic [NREG-1:0]            flag_int_r;
    logic [NREG-1:0]            flag_fp_r;
    logic [NREG-1:0]            flag_int_nxt_s;
    logic [NREG-1:0]            flag_fp_nxt_s;
    logic [NREG-1:0]            busy_int_r;
    logic [NREG-1:0]            busy_fp_r;
    logic [NREG-1:0]            busy_int_nxt_s;
    logic [NREG-1:0]            busy_fp_nxt_s;
    logic [PCNT_W-1:0]          pend_cnt_r;
    logic [PCNT_W-1:0]          pend_cnt_nxt_s;
    logic                       err_r;
    logic                       err_nxt_s;

    logic                       lu_hit_s;
    logic                       raw_hit_s;
    logic                       waw_hit_s;
    logic [1:0]                 stall_cause_s;
    logic                       stall_s;
    logic                       fire_s;
    logic                       issue_s;
    logic                       rd_fp_s;
    logic                       ie_fp_s;
    logic                       clr_fp_s;
    logic [IDX_W-1:0]           rd_idx_s;
    logic [IDX_W-1:0]           clr_idx_s;

    // Same register: equal index and file; integer x0 never matches anything.
    function automatic logic same_reg(input logic [4:0] a_idx, input logic a_fp,
                                      input logic [4:0] b_idx, input logic b_fp);
        return (a_idx == b_idx) && (a_fp == b_fp) && (a_fp || (a_idx != 5'd0));
    endfunction

    // Busy lookup in the selected file.
    function automatic logic reg_busy(input logic [NREG-1:0] b_int,
                                      input logic [NREG-1:0] b_fp,
                                      input logic [IDX_W-1:0] idx,
                                      input logic fp);
        return fp ? b_fp[idx] : b_int[idx];
    endfunction

    // With FLOAT=0 every file select collapses to the integer file.
    assign rd_fp_s   = FLOAT & sb.id_rd_float;
    assign ie_fp_s   = FLOAT & sb.ie_rd_float;
    assign clr_fp_s  = FLOAT & sb.wb_clr_float;
    assign rd_idx_s  = sb.id_rd[IDX_W-1:0];
    assign clr_idx_s = sb.wb_clr_rd[IDX_W-1:0];

    // Hazard detection and cause priority for the instruction in ID.
    always_comb begin
        lu_hit_s  = 1'b0;
        raw_hit_s = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            lu_hit_s  = lu_hit_s | (sb.id_rs_use[i] &
                        same_reg(sb.id_rs[i*5 +: 5], FLOAT & sb.id_rs_float[i],
                                 sb.ie_rd, ie_fp_s));
            raw_hit_s = raw_hit_s | (sb.id_rs_use[i] &
                        reg_busy(busy_int_r, busy_fp_r, sb.id_rs[i*5 +: IDX_W],
                                 FLOAT & sb.id_rs_float[i]));
        end
        lu_hit_s  = lu_hit_s & sb.id_valid & sb.ie_valid & sb.ie_load & sb.ie_wb;
        raw_hit_s = raw_hit_s & sb.id_valid;
        waw_hit_s = sb.id_valid & sb.id_wb &
                    reg_busy(busy_int_r, busy_fp_r, rd_idx_s, rd_fp_s);
        if (lu_hit_s) begin
            stall_cause_s = 2'b01;
        end else if (raw_hit_s) begin
            stall_cause_s = 2'b10;
        end else if (waw_hit_s) begin
            stall_cause_s = 2'b11;
        end else begin
            stall_cause_s = 2'b00;
        end
    end

    assign stall_s = (stall_cause_s != 2'b00);
    assign fire_s  = sb.id_valid & ~stall_s & ~sb.ext_hold;
    // Integer x0 is never tracked, so a long op targeting it allocates nothing.
    assign issue_s = fire_s & sb.id_long & sb.id_wb & (rd_fp_s | (sb.id_rd != 5'd0));

    // Next scoreboard state: countdown, late clear, new issue, then occupancy.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            cnt_int_nxt_s[r] = (cnt_int_r[r] != {CNT_W{1'b0}}) ?
                               (cnt_int_r[r] - CNT_W'(1)) : {CNT_W{1'b0}};
            cnt_fp_nxt_s[r]  = (cnt_fp_r[r] != {CNT_W{1'b0}}) ?
                               (cnt_fp_r[r] - CNT_W'(1)) : {CNT_W{1'b0}};
        end
        flag_int_nxt_s = flag_int_r;
        flag_fp_nxt_s  = flag_fp_r;
        err_nxt_s      = err_r;

        // A clear for a register without a pending unknown-latency op is a
        // protocol error; the state is left untouched.
        if (sb.wb_clr) begin
            if (reg_busy(flag_int_r, flag_fp_r, clr_idx_s, clr_fp_s)) begin
                if (clr_fp_s) begin
                    flag_fp_nxt_s[clr_idx_s] = 1'b0;
                end else begin
                    flag_int_nxt_s[clr_idx_s] = 1'b0;
                end
            end else begin
                err_nxt_s = 1'b1;
            end
        end else begin
            err_nxt_s = err_r;
        end

        // Issue never targets a busy rd (WAW stall), so it cannot collide
        // with the clear above on the same register.
        if (issue_s) begin
            if (sb.id_lat != {CNT_W{1'b0}}) begin
                if (rd_fp_s) begin
                    cnt_fp_nxt_s[rd_idx_s] = sb.id_lat;
                end else begin
                    cnt_int_nxt_s[rd_idx_s] = sb.id_lat;
                end
            end else begin
                if (rd_fp_s) begin
                    flag_fp_nxt_s[rd_idx_s] = 1'b1;
                end else begin
                    flag_int_nxt_s[rd_idx_s] = 1'b1;
                end
            end
        end else begin
            flag_int_nxt_s = flag_int_nxt_s;
        end

        pend_cnt_nxt_s = {PCNT_W{1'b0}};
        for (int r = 0; r < NREG; r++) begin
            busy_int_nxt_s[r] = (cnt_int_nxt_s[r] != {CNT_W{1'b0}}) | flag_int_nxt_s[r];
            busy_fp_nxt_s[r]  = (cnt_fp_nxt_s[r] != {CNT_W{1'b0}}) | flag_fp_nxt_s[r];
            pend_cnt_nxt_s    = pend_cnt_nxt_s + PCNT_W'(busy_int_nxt_s[r])
                                               + PCNT_W'(busy_fp_nxt_s[r]);
        end
    end

    // Scoreboard state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_int_r  <= '0;
            cnt_fp_r   <= '0;
            flag_int_r <= {NREG{1'b0}};
            flag_fp_r  <= {NREG{1'b0}};
            busy_int_r <= {NREG{1'b0}};
            busy_fp_r  <= {NREG{1'b0}};
            pend_cnt_r <= {PCNT_W{1'b0}};
            err_r      <= 1'b0;
        end else begin
            cnt_int_r  <= cnt_int_nxt_s;
            cnt_fp_r   <= cnt_fp_nxt_s;
            flag_int_r <= flag_int_nxt_s;
            flag_fp_r  <= flag_fp_nxt_s;
            busy_int_r <= busy_int_nxt_s;
            busy_fp_r  <= busy_fp_nxt_s;
            pend_cnt_r <= pend_cnt_nxt_s;
            err_r      <= err_nxt_s;
        end
    end

    assign sb.stall       = stall_s;
    assign sb.stall_cause = stall_cause_s;
    assign sb.busy_int    = busy_int_r;
    assign sb.busy_fp     = busy_fp_r;
    assign sb.pend_cnt    = pend_cnt_r;
    assign sb.err         = err_r;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard
// Directed bench for hazard_scoreboard with FLOAT=1. Each step drives the ID,
// IE and WB inputs at the falling edge, queues the values the outputs must
// show in that cycle, and compares them shortly afterwards.
module tb_hazard_scoreboard;
    localparam int NREG  = 32;
    localparam int NSRC  = 3;
    localparam int CNT_W = 6;

    localparam int S_STALL = 0;
    localparam int S_CAUSE = 1;
    localparam int S_BINT  = 2;
    localparam int S_BFP   = 3;
    localparam int S_PEND  = 4;
    localparam int S_ERR   = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;

    hazard_scoreboard_if #(.NREG(NREG), .NSRC(NSRC), .CNT_W(CNT_W)) sb_if ();

    hazard_scoreboard #(.FLOAT(1'b1), .NREG(NREG), .NSRC(NSRC), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .sb  (sb_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        int          sig;
        logic [63:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic expect_out(input string tag, input int sig, input logic [63:0] val);
        exp_t e;
        e.tag = tag;
        e.sig = sig;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic exp_stall(input string tag, input logic st, input logic [1:0] cause);
        expect_out({tag, ".stall"}, S_STALL, 64'(st));
        expect_out({tag, ".cause"}, S_CAUSE, 64'(cause));
    endtask

    task automatic exp_state(input string tag, input logic [63:0] bint, input logic [63:0] bfp,
                             input logic [63:0] pend, input logic [63:0] err);
        expect_out({tag, ".busy_int"}, S_BINT, bint);
        expect_out({tag, ".busy_fp"},  S_BFP,  bfp);
        expect_out({tag, ".pend_cnt"}, S_PEND, pend);
        expect_out({tag, ".err"},      S_ERR,  err);
    endtask

    function automatic logic [63:0] observe(input int sig);
        case (sig)
            S_STALL: observe = 64'(sb_if.stall);
            S_CAUSE: observe = 64'(sb_if.stall_cause);
            S_BINT:  observe = 64'(sb_if.busy_int);
            S_BFP:   observe = 64'(sb_if.busy_fp);
            S_PEND:  observe = 64'(sb_if.pend_cnt);
            default: observe = 64'(sb_if.err);
        endcase
    endfunction

    task automatic drain();
        exp_t        e;
        logic [63:0] obs;
        while (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            obs = observe(e.sig);
            total++;
            assert (obs === e.val) else begin
                bad++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic idle_in();
        sb_if.id_valid     = 1'b0;
        sb_if.id_rs        = '0;
        sb_if.id_rs_use    = 3'b000;
        sb_if.id_rs_float  = 3'b000;
        sb_if.id_rd        = 5'd0;
        sb_if.id_rd_float  = 1'b0;
        sb_if.id_wb        = 1'b0;
        sb_if.id_long      = 1'b0;
        sb_if.id_lat       = 6'd0;
        sb_if.ext_hold     = 1'b0;
        sb_if.ie_valid     = 1'b0;
        sb_if.ie_load      = 1'b0;
        sb_if.ie_rd        = 5'd0;
        sb_if.ie_rd_float  = 1'b0;
        sb_if.ie_wb        = 1'b0;
        sb_if.wb_clr       = 1'b0;
        sb_if.wb_clr_rd    = 5'd0;
        sb_if.wb_clr_float = 1'b0;
    endtask

    task automatic drive_id(input logic [4:0] rs0, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [2:0] use_m, input logic [2:0] fl_m,
                            input logic [4:0] rd, input logic rdf, input logic wb,
                            input logic lng, input logic [5:0] lat);
        sb_if.id_valid    = 1'b1;
        sb_if.id_rs       = {rs2, rs1, rs0};
        sb_if.id_rs_use   = use_m;
        sb_if.id_rs_float = fl_m;
        sb_if.id_rd       = rd;
        sb_if.id_rd_float = rdf;
        sb_if.id_wb       = wb;
        sb_if.id_long     = lng;
        sb_if.id_lat      = lat;
    endtask

    task automatic drive_ie(input logic [4:0] rd, input logic rdf);
        sb_if.ie_valid    = 1'b1;
        sb_if.ie_load     = 1'b1;
        sb_if.ie_rd       = rd;
        sb_if.ie_rd_float = rdf;
        sb_if.ie_wb       = 1'b1;
    endtask

    task automatic drive_clr(input logic [4:0] rd, input logic fl);
        sb_if.wb_clr       = 1'b1;
        sb_if.wb_clr_rd    = rd;
        sb_if.wb_clr_float = fl;
    endtask

    task automatic next_cycle();
        @(negedge clk);
        idle_in();
    endtask

    task automatic sample();
        #1;
        drain();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle_in();
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Reset state
        next_cycle(); rst = 1'b0;
        exp_stall("rst0", 1'b0, 2'b00); exp_state("rst0", 64'h0, 64'h0, 64'd0, 64'd0); sample();

        // Load-use: IE load x5, ID add x6,x5,x1
        next_cycle(); drive_ie(5'd5, 1'b0); drive_id(5'd5, 5'd1, 5'd0, 3'b011, 3'b000, 5'd6, 1'b0, 1'b1, 1'b0, 6'd0);
        exp_stall("lu", 1'b1, 2'b01); sample();
        next_cycle(); drive_id(5'd5, 5'd1, 5'd0, 3'b011, 3'b000, 5'd6, 1'b0, 1'b1, 1'b0, 6'd0);
        exp_stall("lu_bubble", 1'b0, 2'b00); sample();
        next_cycle(); drive_ie(5'd0, 1'b0); drive_id(5'd0, 5'd1, 5'd0, 3'b011, 3'b000, 5'd6, 1'b0, 1'b1, 1'b0, 6'd0);
        exp_stall("lu_x0", 1'b0, 2'b00); sample();
        next_cycle(); drive_ie(5'd5, 1'b1); drive_id(5'd5, 5'd1, 5'd0, 3'b011, 3'b000, 5'd6, 1'b0, 1'b1, 1'b0, 6'd0);
        exp_stall("lu_file", 1'b0, 2'b00); sample();
        next_cycle(); drive_ie(5'd2, 1'b0); drive_id(5'd5, 5'd1, 5'd2, 3'b011, 3'b000, 5'd6, 1'b0, 1'b1, 1'b0, 6'd0);
        exp_stall("lu_unused", 1'b0, 2'b00); sample();

        // Fixed latency: mul x7 lat 3, dependent add x8,x7
        next_cycle(); drive_id(5'd1, 5'd2, 5'd0, 3'b011, 3'b000, 5'd7, 1'b0, 1'b1, 1'b1, 6'd3);
        exp_stall("mul_issue", 1'b0, 2'b00); exp_state("pre_mul", 64'h0, 64'h0, 64'd0, 64'd0); sample();
        for (int k = 1; k <= 3; k++) begin
            next_cycle(); drive_id(5'd7, 5'd0, 5'd0, 3'b001, 3'b000, 5'd8, 1'b0, 1'b1, 1'b0, 6'd0);
            exp_stall($sformatf("raw_fix%0d", k), 1'b1, 2'b10);
            exp_state($sformatf("mul_busy%0d", k), 64'h80, 64'h0, 64'd1, 64'd0); sample();
        end
        next_cycle(); drive_id(5'd7, 5'd0, 5'd0, 3'b001, 3'b000, 5'd8, 1'b0, 1'b1, 1'b0, 6'd0);
        exp_stall("raw_fix_go", 1'b0, 2'b00); exp_state("mul_done", 64'h0, 64'h0, 64'd0, 64'd0); sample();

        // ext_hold blocks issue but counters keep running
        next_cycle(); drive_id(5'd1, 5'd2, 5'd0, 3'b011, 3'b000, 5'd13, 1'b0, 1'b1, 1'b1, 6'd2);
        exp_stall("hold_issue", 1'b0, 2'b00); sample();
        next_cycle(); drive_id(5'd1, 5'd2, 5'd0, 3'b011, 3'b000, 5'd14, 1'b0, 1'b1, 1'b1, 6'd5); sb_if.ext_hold = 1'b1;
        exp_stall("hold_blk", 1'b0, 2'b00); exp_state("hold1", 64'h2000, 64'h0, 64'd1, 64'd0); sample();
        next_cycle(); drive_id(5'd13, 5'd0, 5'd0, 3'b001, 3'b000, 5'd15, 1'b0, 1'b1, 1'b0, 6'd0); sb_if.ext_hold = 1'b1;
        exp_stall("hold_raw", 1'b1, 2'b10); exp_state("hold2", 64'h2000, 64'h0, 64'd1, 64'd0); sample();
        next_cycle(); sb_if.ext_hold = 1'b1;
        exp_state("hold3", 64'h0, 64'h0, 64'd0, 64'd0); sample();

        // Unknown latency: div x9, reader held, then wb_clr
        next_cycle(); drive_id(5'd1, 5'd2, 5'd0, 3'b011, 3'b000, 5'd9, 1'b0, 1'b1, 1'b1, 6'd0);
        exp_stall("div_issue", 1'b0, 2'b00); sample();
        for (int k = 0; k < 20; k++) begin
            next_cycle(); drive_id(5'd0, 5'd9, 5'd0, 3'b010, 3'b000, 5'd8, 1'b0, 1'b1, 1'b0, 6'd0);
            exp_stall($sformatf("raw_unk%0d", k), 1'b1, 2'b10);
            if (k == 0 || k == 19) exp_state($sformatf("div_busy%0d", k), 64'h200, 64'h0, 64'd1, 64'd0);
            sample();
        end
        next_cycle(); drive_id(5'd0, 5'd9, 5'd0, 3'b010, 3'b000, 5'd8, 1'b0, 1'b1, 1'b0, 6'd0); drive_clr(5'd9, 1'b0);
        exp_stall("clr_nobypass", 1'b1, 2'b10); sample();
        next_cycle(); drive_id(5'd0, 5'd9, 5'd0, 3'b010, 3'b000, 5'd8, 1'b0, 1'b1, 1'b0, 6'd0);
        exp_stall("clr_after", 1'b0, 2'b00); exp_state("clr_after", 64'h0, 64'h0, 64'd0, 64'd0); sample();

        // WAW and priority
        next_cycle(); drive_id(5'd1, 5'd2, 5'd0, 3'b011, 3'b000, 5'd9, 1'b0, 1'b1, 1'b1, 6'd0);
        exp_stall("div2", 1'b0, 2'b00); sample();
        next_cycle(); drive_id(5'd1, 5'd0, 5'd0, 3'b001, 3'b000, 5'd9, 1'b0, 1'b1, 1'b0, 6'd0);
        exp_stall("waw", 1'b1, 2'b11); sample();
        next_cycle(); drive_id(5'd1, 5'd0, 5'd0, 3'b001, 3'b000, 5'd9, 1'b0, 1'b1, 1'b0, 6'd0); drive_ie(5'd1, 1'b0);
        exp_stall("prio_lu", 1'b1, 2'b01); sample();
        next_cycle(); drive_id(5'd9, 5'd0, 5'd0, 3'b001, 3'b000, 5'd9, 1'b0, 1'b1, 1'b0, 6'd0);
        exp_stall("prio_raw", 1'b1, 2'b10); sample();
        // Same-cycle clear of x9 and issue of mul x10 lat 2
        next_cycle(); drive_clr(5'd9, 1'b0); drive_id(5'd1, 5'd2, 5'd0, 3'b011, 3'b000, 5'd10, 1'b0, 1'b1, 1'b1, 6'd2);
        exp_stall("clr_issue", 1'b0, 2'b00); exp_state("clr_issue_pre", 64'h200, 64'h0, 64'd1, 64'd0); sample();
        next_cycle(); exp_state("clr_issue_st", 64'h400, 64'h0, 64'd1, 64'd0); sample();
        next_cycle(); exp_state("x10_last", 64'h400, 64'h0, 64'd1, 64'd0); sample();
        next_cycle(); exp_state("x10_done", 64'h0, 64'h0, 64'd0, 64'd0); sample();

        // Float file separation and stray clear
        next_cycle(); drive_id(5'd1, 5'd2, 5'd0, 3'b011, 3'b011, 5'd3, 1'b1, 1'b1, 1'b1, 6'd0);
        exp_stall("fdiv", 1'b0, 2'b00); sample();
        next_cycle(); drive_id(5'd3, 5'd0, 5'd0, 3'b001, 3'b000, 5'd8, 1'b0, 1'b1, 1'b0, 6'd0);
        exp_stall("int_x3", 1'b0, 2'b00); exp_state("fdiv_st", 64'h0, 64'h8, 64'd1, 64'd0); sample();
        next_cycle(); drive_id(5'd1, 5'd2, 5'd3, 3'b111, 3'b111, 5'd4, 1'b1, 1'b1, 1'b1, 6'd4);
        exp_stall("fmadd_rs3", 1'b1, 2'b10); sample();
        next_cycle(); drive_clr(5'd4, 1'b1);
        exp_state("stray_pre", 64'h0, 64'h8, 64'd1, 64'd0); sample();
        next_cycle(); exp_state("stray_err", 64'h0, 64'h8, 64'd1, 64'd1); sample();
        next_cycle(); exp_state("err_sticky", 64'h0, 64'h8, 64'd1, 64'd1); sample();

        // Reset with three registers pending
        next_cycle(); drive_id(5'd1, 5'd2, 5'd0, 3'b011, 3'b000, 5'd11, 1'b0, 1'b1, 1'b1, 6'd30);
        exp_stall("mul11", 1'b0, 2'b00); sample();
        next_cycle(); drive_id(5'd1, 5'd2, 5'd0, 3'b011, 3'b000, 5'd12, 1'b0, 1'b1, 1'b1, 6'd0);
        exp_stall("div12", 1'b0, 2'b00); sample();
        next_cycle(); exp_state("three_pend", 64'h1800, 64'h8, 64'd3, 64'd1); sample();
        next_cycle(); rst = 1'b1;
        next_cycle(); rst = 1'b0; drive_id(5'd11, 5'd12, 5'd3, 3'b111, 3'b100, 5'd12, 1'b0, 1'b1, 1'b0, 6'd0);
        exp_stall("rst_mid", 1'b0, 2'b00); exp_state("rst_mid", 64'h0, 64'h0, 64'd0, 64'd0); sample();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
